seg_to_bin: RTL and testbench
=============================

SEG_TO_BIN -- requirements
Module: seg_to_bin

Interface
REQ-001 SHALL have parameter STABLE_FRAMES, default 2: consecutive identical legal frames required before a value is published (range 1..7).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 3000000: clock cycles without any select rising edge before stale asserts (30 ms at 100 MHz).
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port dk, input, 7: active-high segments; dk[6]=a … dk[0]=g.
REQ-006 SHALL have port select_1, input, 1: tens digit strobe (high while dk carries the tens digit).
REQ-007 SHALL have port select_2, input, 1: units digit strobe.
REQ-008 SHALL have port value, output, 4: last published binary value, 0..15.
REQ-009 SHALL have port valid, output, 1: one-cycle pulse when value is updated.
REQ-010 SHALL have port err, output, 1: one-cycle pulse per rejected frame.
REQ-011 SHALL have port stale, output, 1: level, no strobe activity within TIMEOUT_CYC.

Function
REQ-012 SHALL register dk, select_1 and select_2 once; all decisions use the registered copies.
REQ-013 SHALL detect a rising edge of each registered select against its previous-cycle value and latch registered dk on that cycle.
REQ-014 SHALL decode patterns 0-9 as: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011; any other pattern is illegal.
REQ-015 SHALL use FSM states WAIT_T and WAIT_U; reset to WAIT_T.
REQ-016 In WAIT_T: a select_1 edge latches the tens pattern and moves to WAIT_U; a select_2 edge is ignored.
REQ-017 In WAIT_U: a select_1 edge overwrites the tens pattern and stays; a select_2 edge latches units, completes the frame and returns to WAIT_T.
REQ-018 A frame is legal only if tens decodes to 0 or 1, units decodes to a digit, and tens*10+units <= 15.
REQ-019 Registered select_1 and select_2 both high in any cycle SHALL abort the frame: err pulse, FSM to WAIT_T.
REQ-020 An illegal frame SHALL pulse err, clear the match counter, invalidate the candidate and leave value unchanged.
REQ-021 A legal frame equal to the candidate SHALL increment the match counter (saturating at STABLE_FRAMES); otherwise it becomes the candidate with the counter at 1.
REQ-022 When the counter reaches STABLE_FRAMES and the candidate differs from value, or no value has been published since reset, value SHALL update and valid SHALL pulse, exactly 2 cycles after the cycle in which the completing select_2 edge is detected.
REQ-023 A saturated counter with an unchanged candidate SHALL NOT re-pulse valid.
REQ-024 err and valid SHALL never assert in the same cycle.

Reset
REQ-025 On rst: value=0, valid=0, err=0, stale=0, FSM=WAIT_T, counters=0, candidate invalid, published flag cleared, input registers cleared.
REQ-026 rst asserted mid-frame SHALL discard the partial frame; no valid or err pulse results from it.

Configuration
REQ-027 Macro SEG_TO_BIN_TIMEOUT_EN defined: an idle counter clears on any select edge; when it reaches TIMEOUT_CYC, stale sets and the FSM returns to WAIT_T; stale clears on the next select edge.
REQ-028 Macro SEG_TO_BIN_TIMEOUT_EN undefined: no idle counter is built and stale is tied to 0.

Verification
REQ-029 Two frames of tens=1111110, units=1111111 -> one valid pulse after the second frame, value=8.
REQ-030 Frames tens=0110000, units=1111001 repeated -> value=13; further identical frames produce no additional valid pulse.
REQ-031 Frame tens=0110000, units=1011111 (16) -> err pulse, value unchanged, no valid pulse.
REQ-032 select_1 and select_2 high together -> err pulse, FSM returns to WAIT_T; a following legal frame pair still publishes.
REQ-033 rst pulsed between the tens and units strobes -> no pulses, all outputs 0; the next two good frames of 5 -> value=5.
REQ-034 With SEG_TO_BIN_TIMEOUT_EN and TIMEOUT_CYC=100: strobes stop -> stale=1 after 100 cycles; the next select edge -> stale=0.

Source files
------------

// File: rtl/seg_to_bin.sv
//----------------------------------------------------------------------------
// Module      : seg_to_bin
// Description : Two-digit seven-segment frame to 4-bit binary converter.
//               Frames need STABLE_FRAMES consecutive matches before they
//               are published. Optional idle watchdog: SEG_TO_BIN_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module seg_to_bin #(
  parameter int STABLE_FRAMES = 2,
  parameter int TIMEOUT_CYC   = 3000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] dk,
  input  logic       select_1,
  input  logic       select_2,
  output logic [3:0] value,
  output logic       valid,
  output logic       err,
  output logic       stale
);

  typedef enum logic [0:0] {
    WAIT_T = 1'b0,
    WAIT_U = 1'b1
  } state_t;

  localparam logic [2:0] c_STABLE = 3'(STABLE_FRAMES);

  // Input capture and edge history
  logic [6:0] dk_q;
  logic       s1_q, s2_q, s1p_q, s2p_q;

  state_t     state_q, state_d;
  logic [6:0] tens_q, tens_d, units_q, units_d;
  logic       done_q, done_d, abort_q, abort_d;

  logic [3:0] cand_q, cand_d;
  logic       cand_vld_q, cand_vld_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] value_q, value_d;
  logic       pub_q, pub_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  logic       w_e1, w_e2, w_both, w_both_prev, w_any_edge, w_timeout;
  logic [4:0] w_td, w_ud, w_sum;
  logic       w_legal;

  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'b1111110: seg_decode = {1'b1, 4'd0};
      7'b0110000: seg_decode = {1'b1, 4'd1};
      7'b1101101: seg_decode = {1'b1, 4'd2};
      7'b1111001: seg_decode = {1'b1, 4'd3};
      7'b0110011: seg_decode = {1'b1, 4'd4};
      7'b1011011: seg_decode = {1'b1, 4'd5};
      7'b1011111: seg_decode = {1'b1, 4'd6};
      7'b1110000: seg_decode = {1'b1, 4'd7};
      7'b1111111: seg_decode = {1'b1, 4'd8};
      7'b1111011: seg_decode = {1'b1, 4'd9};
      default:    seg_decode = 5'd0;
    endcase
  endfunction

  assign w_e1        = s1_q & ~s1p_q;
  assign w_e2        = s2_q & ~s2p_q;
  assign w_both      = s1_q & s2_q;
  assign w_both_prev = s1p_q & s2p_q;
  assign w_any_edge  = w_e1 | w_e2;

  always_ff @(posedge clk) begin
    if (rst) begin
      dk_q  <= '0;
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s1p_q <= 1'b0;
      s2p_q <= 1'b0;
    end else begin
      dk_q  <= dk;
      s1_q  <= select_1;
      s2_q  <= select_2;
      s1p_q <= s1_q;
      s2p_q <= s2_q;
    end
  end

  // Frame assembly FSM; an overlap of both strobes errs once per overlap
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    units_d = units_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    if (w_both) begin
      state_d = WAIT_T;
      abort_d = ~w_both_prev;
    end else if (w_timeout) begin
      state_d = WAIT_T;
    end else begin
      case (state_q)
        WAIT_T: begin
          if (w_e1) begin
            tens_d  = dk_q;
            state_d = WAIT_U;
          end
        end
        WAIT_U: begin
          if (w_e1) begin
            tens_d = dk_q;
          end else if (w_e2) begin
            units_d = dk_q;
            done_d  = 1'b1;
            state_d = WAIT_T;
          end
        end
        default: state_d = WAIT_T;
      endcase
    end
  end

  assign w_td    = seg_decode(tens_q);
  assign w_ud    = seg_decode(units_q);
  assign w_sum   = (w_td[3:0] == 4'd1) ? (5'd10 + {1'b0, w_ud[3:0]}) : {1'b0, w_ud[3:0]};
  assign w_legal = w_td[4] & w_ud[4] & (w_td[3:0] <= 4'd1) & (w_sum <= 5'd15);

  // Stability filter and publish stage, one cycle after frame completion
  always_comb begin
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
    cnt_d      = cnt_q;
    value_d    = value_q;
    pub_d      = pub_q;
    valid_d    = 1'b0;
    err_d      = abort_q;
    if (done_q) begin
      if (!w_legal) begin
        err_d      = 1'b1;
        cnt_d      = 3'd0;
        cand_vld_d = 1'b0;
      end else begin
        if (cand_vld_q && (cand_q == w_sum[3:0])) begin
          if (cnt_q != c_STABLE) begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          cand_d     = w_sum[3:0];
          cand_vld_d = 1'b1;
          cnt_d      = 3'd1;
        end
        if ((cnt_d == c_STABLE) && ((cand_d != value_q) || !pub_q)) begin
          value_d = cand_d;
          valid_d = 1'b1;
          pub_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_T;
      tens_q     <= '0;
      units_q    <= '0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
      cnt_q      <= '0;
      value_q    <= '0;
      pub_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
      cnt_q      <= cnt_d;
      value_q    <= value_d;
      pub_q      <= pub_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

`ifdef SEG_TO_BIN_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] c_TIMEOUT = IW'(TIMEOUT_CYC);

  logic [IW-1:0] idle_q, idle_d;
  logic          stale_q, stale_d;

  always_comb begin
    idle_d    = idle_q;
    stale_d   = stale_q;
    w_timeout = 1'b0;
    if (w_any_edge) begin
      idle_d  = '0;
      stale_d = 1'b0;
    end else if (idle_q != c_TIMEOUT) begin
      idle_d = idle_q + 1'b1;
      if (idle_d == c_TIMEOUT) begin
        stale_d   = 1'b1;
        w_timeout = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q  <= '0;
      stale_q <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      stale_q <= stale_d;
    end
  end

  assign stale = stale_q;
`else
  assign w_timeout = 1'b0;
  assign stale     = 1'b0;
`endif

  assign value = value_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_to_bin.sv
//----------------------------------------------------------------------------
// Module      : tb_seg_to_bin
// Description : Directed self-checking bench for seg_to_bin.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_seg_to_bin;

  localparam logic [6:0] c_S0 = 7'b1111110;
  localparam logic [6:0] c_S1 = 7'b0110000;
  localparam logic [6:0] c_S3 = 7'b1111001;
  localparam logic [6:0] c_S5 = 7'b1011011;
  localparam logic [6:0] c_S6 = 7'b1011111;
  localparam logic [6:0] c_S8 = 7'b1111111;
  localparam logic [6:0] c_S9 = 7'b1111011;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] dk;
  logic       select_1, select_2;
  logic [3:0] value;
  logic       valid, err, stale;

  int cmp_cnt = 0;
  int fail_cnt = 0;
  int v_cnt = 0;
  int e_cnt = 0;
  logic both_seen = 1'b0;

  seg_to_bin #(
    .STABLE_FRAMES(2),
    .TIMEOUT_CYC  (100)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .dk      (dk),
    .select_1(select_1),
    .select_2(select_2),
    .value   (value),
    .valid   (valid),
    .err     (err),
    .stale   (stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) v_cnt++;
    if (err) e_cnt++;
    if (valid && err) both_seen = 1'b1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Tens strobe, gap, units strobe; reports tick index (1..4) of first valid/err after units
  task automatic send_frame(input logic [6:0] tens, input logic [6:0] units,
                            output int vat, output int eat);
    vat = 0;
    eat = 0;
    dk = tens; select_1 = 1'b1; tick();
    select_1 = 1'b0; tick();
    dk = units; select_2 = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      select_2 = 1'b0;
      if (valid && vat == 0) vat = t;
      if (err && eat == 0) eat = t;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; dk = '0; select_1 = 1'b0; select_2 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    cmp_cnt++; if (value !== 4'd0) begin fail_cnt++; $display("FAIL reset_value got=%0d exp=0", value); end
    cmp_cnt++; if (valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_valid got=%b exp=0", valid); end
    cmp_cnt++; if (err !== 1'b0) begin fail_cnt++; $display("FAIL reset_err got=%b exp=0", err); end
    cmp_cnt++; if (stale !== 1'b0) begin fail_cnt++; $display("FAIL reset_stale got=%b exp=0", stale); end
  endtask

  task automatic test_zero_publish;
    int vat, eat;
    send_frame(c_S0, c_S0, vat, eat);
    cmp_cnt++; if (vat !== 0) begin fail_cnt++; $display("FAIL zero_first_valid got=%0d exp=0", vat); end
    send_frame(c_S0, c_S0, vat, eat);
    cmp_cnt++; if (vat !== 3) begin fail_cnt++; $display("FAIL zero_second_valid_at got=%0d exp=3", vat); end
    cmp_cnt++; if (value !== 4'd0) begin fail_cnt++; $display("FAIL zero_value got=%0d exp=0", value); end
  endtask

  task automatic test_eight;
    int vat, eat, v0, e0;
    v0 = v_cnt; e0 = e_cnt;
    send_frame(c_S0, c_S8, vat, eat);
    cmp_cnt++; if (vat !== 0) begin fail_cnt++; $display("FAIL eight_first_valid got=%0d exp=0", vat); end
    send_frame(c_S0, c_S8, vat, eat);
    cmp_cnt++; if (vat !== 3) begin fail_cnt++; $display("FAIL eight_latency got=%0d exp=3", vat); end
    cmp_cnt++; if (value !== 4'd8) begin fail_cnt++; $display("FAIL eight_value got=%0d exp=8", value); end
    cmp_cnt++; if ((v_cnt - v0) !== 1) begin fail_cnt++; $display("FAIL eight_pulses got=%0d exp=1", v_cnt - v0); end
    cmp_cnt++; if ((e_cnt - e0) !== 0) begin fail_cnt++; $display("FAIL eight_err got=%0d exp=0", e_cnt - e0); end
  endtask

  task automatic test_thirteen_repeat;
    int vat, eat, v0;
    send_frame(c_S1, c_S3, vat, eat);
    send_frame(c_S1, c_S3, vat, eat);
    cmp_cnt++; if (value !== 4'd13) begin fail_cnt++; $display("FAIL thirteen_value got=%0d exp=13", value); end
    v0 = v_cnt;
    send_frame(c_S1, c_S3, vat, eat);
    send_frame(c_S1, c_S3, vat, eat);
    cmp_cnt++; if ((v_cnt - v0) !== 0) begin fail_cnt++; $display("FAIL thirteen_repulse got=%0d exp=0", v_cnt - v0); end
  endtask

  task automatic test_out_of_range;
    int vat, eat;
    send_frame(c_S1, c_S6, vat, eat);
    cmp_cnt++; if (eat !== 3) begin fail_cnt++; $display("FAIL sixteen_err_at got=%0d exp=3", eat); end
    cmp_cnt++; if (vat !== 0) begin fail_cnt++; $display("FAIL sixteen_valid got=%0d exp=0", vat); end
    cmp_cnt++; if (value !== 4'd13) begin fail_cnt++; $display("FAIL sixteen_value got=%0d exp=13", value); end
    send_frame(c_S1, c_S5, vat, eat);
    send_frame(c_S1, c_S5, vat, eat);
    cmp_cnt++; if (value !== 4'd15) begin fail_cnt++; $display("FAIL fifteen_value got=%0d exp=15", value); end
  endtask

  task automatic test_abort;
    int vat, eat, v0, e0, eat_abort;
    v0 = v_cnt; e0 = e_cnt; eat_abort = 0;
    dk = c_S1; select_1 = 1'b1; tick();
    select_1 = 1'b0; tick();
    select_1 = 1'b1; select_2 = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      select_1 = 1'b0; select_2 = 1'b0;
      if (err && eat_abort == 0) eat_abort = t;
    end
    cmp_cnt++; if (eat_abort !== 3) begin fail_cnt++; $display("FAIL abort_err_at got=%0d exp=3", eat_abort); end
    cmp_cnt++; if ((e_cnt - e0) !== 1) begin fail_cnt++; $display("FAIL abort_err_count got=%0d exp=1", e_cnt - e0); end
    cmp_cnt++; if ((v_cnt - v0) !== 0) begin fail_cnt++; $display("FAIL abort_valid got=%0d exp=0", v_cnt - v0); end
    send_frame(c_S0, c_S9, vat, eat);
    send_frame(c_S0, c_S9, vat, eat);
    cmp_cnt++; if (vat !== 3) begin fail_cnt++; $display("FAIL abort_recover_at got=%0d exp=3", vat); end
    cmp_cnt++; if (value !== 4'd9) begin fail_cnt++; $display("FAIL abort_recover_value got=%0d exp=9", value); end
  endtask

  task automatic test_reset_mid_frame;
    int vat, eat, v0, e0;
    dk = c_S0; select_1 = 1'b1; tick();
    select_1 = 1'b0; tick();
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    v0 = v_cnt; e0 = e_cnt;
    dk = c_S5; select_2 = 1'b1; tick();
    select_2 = 1'b0;
    repeat (4) tick();
    cmp_cnt++; if ((v_cnt - v0) !== 0 || (e_cnt - e0) !== 0) begin
      fail_cnt++; $display("FAIL midrst_pulses valid=%0d err=%0d exp=0/0", v_cnt - v0, e_cnt - e0);
    end
    cmp_cnt++; if (value !== 4'd0) begin fail_cnt++; $display("FAIL midrst_value got=%0d exp=0", value); end
    send_frame(c_S0, c_S5, vat, eat);
    cmp_cnt++; if (vat !== 0) begin fail_cnt++; $display("FAIL midrst_first_valid got=%0d exp=0", vat); end
    send_frame(c_S0, c_S5, vat, eat);
    cmp_cnt++; if (value !== 4'd5) begin fail_cnt++; $display("FAIL midrst_value5 got=%0d exp=5", value); end
    cmp_cnt++; if (both_seen !== 1'b0) begin fail_cnt++; $display("FAIL valid_err_overlap got=%b exp=0", both_seen); end
  endtask

  task automatic test_stale;
`ifdef SEG_TO_BIN_TIMEOUT_EN
    repeat (90) tick();
    cmp_cnt++; if (stale !== 1'b0) begin fail_cnt++; $display("FAIL stale_early got=%b exp=0", stale); end
    repeat (20) tick();
    cmp_cnt++; if (stale !== 1'b1) begin fail_cnt++; $display("FAIL stale_set got=%b exp=1", stale); end
    select_1 = 1'b1; dk = c_S1; tick();
    select_1 = 1'b0; tick(); tick();
    cmp_cnt++; if (stale !== 1'b0) begin fail_cnt++; $display("FAIL stale_clear got=%b exp=0", stale); end
`else
    repeat (150) tick();
    cmp_cnt++; if (stale !== 1'b0) begin fail_cnt++; $display("FAIL stale_tied got=%b exp=0", stale); end
`endif
  endtask

  initial begin
    test_reset();
    test_zero_publish();
    test_eight();
    test_thirteen_repeat();
    test_out_of_range();
    test_abort();
    test_reset_mid_frame();
    test_stale();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

`default_nettype wire
